// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared helpers for the integer clock divider
package clk_div_pkg;
  function automatic int high_len(input int p);
    return (p + 1) / 2;
  endfunction
endpackage

// File: rtl/clk_div_counter.sv
// clk_div_counter: modulo-P phase counter with look-ahead next value
module clk_div_counter #(
  parameter int P = 5,
  parameter int W = $clog2(P)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_cnt_next
);
  logic [W-1:0] r_cnt;
  logic         w_wrap;
  assign w_wrap     = r_cnt == W'(P - 1);
  assign o_cnt_next = w_wrap ? '0 : r_cnt + 1'b1;
  assign o_cnt      = r_cnt;
  // Reset parks at P-1 so the first edge after release starts a fresh period
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= W'(P - 1);
    else          r_cnt <= o_cnt_next;
endmodule

// File: rtl/clk_div.sv
// clk_div: 50%-duty divide-by-P clock, one-cycle enable strobe and phase count
module clk_div
  import clk_div_pkg::*;
#(
  parameter  int P = 5,
  localparam int W = $clog2(P)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  output logic         o_clk_out,
  output logic         o_ce,
  output logic [W-1:0] o_cnt
);
  localparam int H = high_len(P);
  if (P < 2) begin : g_bad_p
    $error("clk_div: P must be >= 2");
  end
  logic [W-1:0] w_cnt_next;
  logic         r_ce;
  logic         r_q_pos;
  clk_div_counter #(.P(P), .W(W)) u_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .o_cnt      (o_cnt),
    .o_cnt_next (w_cnt_next)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_ce    <= 1'b0;
      r_q_pos <= 1'b0;
    end else begin
      r_ce    <= w_cnt_next == W'(P - 1);
      r_q_pos <= w_cnt_next < W'(H);
    end
  assign o_ce = r_ce;
  if (P % 2 == 1) begin : g_odd
    // Half-cycle delayed copy trims the extra half cycle of high time
    logic r_q_neg;
    always_ff @(negedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_q_neg <= 1'b0;
      else          r_q_neg <= r_q_pos;
    assign o_clk_out = r_q_pos & r_q_neg;
  end else begin : g_even
    assign o_clk_out = r_q_pos;
  end
endmodule

// File: tb/tb_clk_div.sv
// tb_clk_div: table-driven and scoreboard checks of clk_div for P = 5, 4, 2, 7
`timescale 1ns/1ps
module tb_clk_div;
  typedef struct {int cnt; bit ce; bit cr; bit cf;} vec_t;
  typedef struct {int idx; int cnt; bit ce; bit cr; bit cf;} sb_t;
  localparam int PS [4] = '{5, 4, 2, 7};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic co5, ce5, co4, ce4, co2, ce2, co7, ce7;
  logic [2:0] cnt5;
  logic [1:0] cnt4;
  logic [0:0] cnt2;
  logic [2:0] cnt7;
  int checks = 0;
  int failures = 0;
  sb_t sbq [$];
  always #5 clk = ~clk;
  clk_div #(.P(5)) u5 (.i_clk(clk), .i_rst_n(rst_n), .o_clk_out(co5), .o_ce(ce5), .o_cnt(cnt5));
  clk_div #(.P(4)) u4 (.i_clk(clk), .i_rst_n(rst_n), .o_clk_out(co4), .o_ce(ce4), .o_cnt(cnt4));
  clk_div #(.P(2)) u2 (.i_clk(clk), .i_rst_n(rst_n), .o_clk_out(co2), .o_ce(ce2), .o_cnt(cnt2));
  clk_div #(.P(7)) u7 (.i_clk(clk), .i_rst_n(rst_n), .o_clk_out(co7), .o_ce(ce7), .o_cnt(cnt7));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sample(input int idx, output int c, output bit e, output bit o);
    case (idx)
      0:       begin c = int'(cnt5); e = ce5; o = co5; end
      1:       begin c = int'(cnt4); e = ce4; o = co4; end
      2:       begin c = int'(cnt2); e = ce2; o = co2; end
      default: begin c = int'(cnt7); e = ce7; o = co7; end
    endcase
  endtask

  // Expected behaviour k rising edges after reset release, derived from the timing rules
  function automatic sb_t expect_at(input int idx, input int k);
    sb_t s;
    int p, h;
    p = PS[idx];
    h = (p % 2 == 1) ? (p + 1) / 2 : p / 2;
    s.idx = idx;
    s.cnt = (k == 0) ? p - 1 : (k - 1) % p;
    s.ce  = (k > 0) && (s.cnt == p - 1);
    s.cf  = (k > 0) && (s.cnt < h);
    s.cr  = (p % 2 == 1) ? (s.cf && s.cnt != 0) : s.cf;
    return s;
  endfunction

  task automatic measure(input int idx, output int hi, output int lo);
    int st, c;
    bit e, prev, cur;
    time tr, tf;
    st = 0; tr = 0; tf = 0; hi = -1; lo = -1;
    sample(idx, c, e, prev);
    for (int i = 0; i < 60 && st < 3; i++) begin
      @(clk); #1;
      sample(idx, c, e, cur);
      if (cur && !prev) begin
        if (st == 0) begin tr = $time; st = 1; end
        else if (st == 2) begin lo = int'($time - tf); st = 3; end
      end else if (!cur && prev && st == 1) begin
        tf = $time; hi = int'($time - tr); st = 2;
      end
      prev = cur;
    end
  endtask

  task automatic release_reset();
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t tbl [7];
    int c, hi, lo, ce_cnt;
    bit e, o, found;
    sb_t s;
    tbl[0] = '{4, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 1};
    tbl[2] = '{1, 0, 1, 1};
    tbl[3] = '{2, 0, 1, 1};
    tbl[4] = '{3, 0, 0, 0};
    tbl[5] = '{4, 1, 0, 0};
    tbl[6] = '{0, 0, 0, 1};
    #97;
    sample(0, c, e, o);
    chk("reset_cnt5", c, tbl[0].cnt);
    chk("reset_ce5", int'(e), int'(tbl[0].ce));
    chk("reset_clk5", int'(o), int'(tbl[0].cr));
    release_reset();
    for (int k = 1; k < 7; k++) begin
      @(posedge clk); #1;
      sample(0, c, e, o);
      chk($sformatf("tbl%0d_cnt5", k), c, tbl[k].cnt);
      chk($sformatf("tbl%0d_ce5", k), int'(e), int'(tbl[k].ce));
      chk($sformatf("tbl%0d_clk5_rise", k), int'(o), int'(tbl[k].cr));
      @(negedge clk); #1;
      sample(0, c, e, o);
      chk($sformatf("tbl%0d_clk5_fall", k), int'(o), int'(tbl[k].cf));
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      s = expect_at(i, 0);
      sample(i, c, e, o);
      chk($sformatf("rst_cnt_p%0d", PS[i]), c, s.cnt);
      chk($sformatf("rst_ce_p%0d", PS[i]), int'(e), int'(s.ce));
      chk($sformatf("rst_clk_p%0d", PS[i]), int'(o), int'(s.cr));
    end
    release_reset();
    ce_cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      for (int i = 0; i < 4; i++) sbq.push_back(expect_at(i, k));
      #1;
      foreach (sbq[j]) begin
        sample(sbq[j].idx, c, e, o);
        chk($sformatf("sb_cnt_p%0d_k%0d", PS[sbq[j].idx], k), c, sbq[j].cnt);
        chk($sformatf("sb_ce_p%0d_k%0d", PS[sbq[j].idx], k), int'(e), int'(sbq[j].ce));
        chk($sformatf("sb_clkr_p%0d_k%0d", PS[sbq[j].idx], k), int'(o), int'(sbq[j].cr));
        if (sbq[j].idx == 0 && e) ce_cnt++;
      end
      @(negedge clk); #1;
      while (sbq.size() > 0) begin
        s = sbq.pop_front();
        sample(s.idx, c, e, o);
        chk($sformatf("sb_clkf_p%0d_k%0d", PS[s.idx], k), int'(o), int'(s.cf));
      end
    end
    chk("ce5_pulses_100", ce_cnt, 20);
    measure(0, hi, lo);
    chk("p5_high_ns", hi, 25);
    chk("p5_low_ns", lo, 25);
    measure(1, hi, lo);
    chk("p4_high_ns", hi, 20);
    chk("p4_low_ns", lo, 20);
    measure(3, hi, lo);
    chk("p7_high_ns", hi, 35);
    chk("p7_low_ns", lo, 35);
    rst_n = 1'b0;
    #13;
    release_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      sample(0, c, e, o);
      found = (c == 2) && o;
    end
    chk("midrst_found_cnt2_high", int'(found), 1);
    #2;
    rst_n = 1'b0;
    #1;
    sample(0, c, e, o);
    chk("midrst_cnt5", c, 4);
    chk("midrst_ce5", int'(e), 0);
    chk("midrst_clk5", int'(o), 0);
    release_reset();
    measure(0, hi, lo);
    chk("midrst_high_ns", hi, 25);
    chk("midrst_low_ns", lo, 25);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
